// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start(0), LSB-first data, optional even parity, stop(1); accept-to-line latency 1 clk.
// Backpressure: tx_ready is high only in IDLE (including the done cycle), so words are held off for the whole frame.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              busy,
    output logic              done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W  = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              parity;
    logic              baud_wrap;
    logic [DATA_W-1:0] sh_next;

    assign baud_wrap = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign sh_next   = shreg >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_line  <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud     <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            parity   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                baud <= baud_wrap ? '0 : baud + BAUD_W'(1);
            end
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg    <= tx_data;
                        parity   <= ^tx_data;
                        state    <= START;
                        tx_line  <= 1'b0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        baud     <= '0;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        state   <= DATA;
                        tx_line <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            // Parity is precomputed at accept, so no running XOR is needed here.
                            if (PARITY_EN != 0) begin
                                state   <= PARITY;
                                tx_line <= parity;
                            end else begin
                                state   <= STOP;
                                tx_line <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= sh_next;
                            tx_line <= sh_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (baud_wrap) begin
                        state   <= STOP;
                        tx_line <= 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        state    <= IDLE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        tx_line  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_line  <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule
